// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a single synchronous-read RAM.
// Round-robin with a per-port burst cap; read data returns to the issuer one cycle later.
module ram_port_arbiter #(
   parameter int AW        = 8,
   parameter int DW        = 16,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   output logic          rvalid0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic          rvalid1,
   output logic [DW-1:0] rdata1,
   output logic          ram_w_en,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_w_data,
   input  logic [DW-1:0] ram_r_data,
   output logic          busy
);

   localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

   logic       last_q, last_d;
   logic [3:0] run_q, run_d;
   logic       prev_q, prev_d;       // some port was granted last cycle
   logic       rd_pend_q, rd_pend_d;
   logic       rd_port_q, rd_port_d;
   logic       sel;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      sel  = 1'b0;
      if (!rst) begin
         if (req0 && req1) begin
            // the previous owner keeps the bus only while its burst is still live
            sel  = (prev_q && run_q < BURST_LIM) ? last_q : ~last_q;
            gnt0 = ~sel;
            gnt1 = sel;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   always_comb begin
      ram_w_en   = 1'b0;
      ram_addr   = '0;
      ram_w_data = '0;
      if (gnt0) begin
         ram_w_en   = we0;
         ram_addr   = addr0;
         ram_w_data = wdata0;
      end else if (gnt1) begin
         ram_w_en   = we1;
         ram_addr   = addr1;
         ram_w_data = wdata1;
      end
   end

   always_comb begin
      last_d    = last_q;
      run_d     = run_q;
      prev_d    = gnt0 | gnt1;
      rd_pend_d = (gnt0 | gnt1) & ~ram_w_en;
      rd_port_d = rd_port_q;
      if (gnt0 | gnt1) begin
         rd_port_d = gnt1;
         last_d    = gnt1;
         if (gnt1 == last_q) run_d = (run_q == 4'd15) ? 4'd15 : run_q + 4'd1;
         else                run_d = 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q    <= 1'b1;
         run_q     <= 4'd0;
         prev_q    <= 1'b0;
         rd_pend_q <= 1'b0;
         rd_port_q <= 1'b0;
      end else begin
         last_q    <= last_d;
         run_q     <= run_d;
         prev_q    <= prev_d;
         rd_pend_q <= rd_pend_d;
         rd_port_q <= rd_port_d;
      end
   end

   // a read caught by reset is dropped: the return is masked in the reset cycle
   assign rvalid0 = ~rst & rd_pend_q & ~rd_port_q;
   assign rvalid1 = ~rst & rd_pend_q &  rd_port_q;
   assign rdata0  = rvalid0 ? ram_r_data : '0;
   assign rdata1  = rvalid1 ? ram_r_data : '0;
   assign busy    = ~rst & (req0 | req1 | rd_pend_q);

endmodule
